// File: rtl/sfp_vec_div_s_pkg.sv
// Shared types and helpers for the signed fixed-point vector/scalar divider.
package sfp_vec_div_s_pkg;

    // Divider control FSM states.
    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StDiv,
        StFix,
        StDone
    } div_state_e;

    // Width of the signed scratch arithmetic used for range checks.
    localparam int unsigned SfpCalcW = 64;

    // Largest value representable in a w-bit two's complement word.
    function automatic logic signed [SfpCalcW-1:0] sfp_max(input int unsigned w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    // Smallest value representable in a w-bit two's complement word.
    function automatic logic signed [SfpCalcW-1:0] sfp_min(input int unsigned w);
        return -(64'sd1 <<< (w - 1));
    endfunction

    // Clamp a wide signed value into the w-bit two's complement range.
    function automatic logic signed [SfpCalcW-1:0] sfp_sat(input logic signed [SfpCalcW-1:0] value,
                                                           input int unsigned w);
        if (value > sfp_max(w)) begin
            return sfp_max(w);
        end else if (value < sfp_min(w)) begin
            return sfp_min(w);
        end
        return value;
    endfunction

endpackage

// File: rtl/sfp_vec_div_s_div_seq.sv
// Single-component restoring divider: unsigned magnitudes, one quotient bit per cycle, MSB first.
// A start pulse loads the operands; done_o is high during the last of DvdW step cycles, and the
// quotient is available on quotient_o from the following cycle until the next start.
module sfp_vec_div_s_div_seq #(
    parameter int unsigned DvdW = 24,
    parameter int unsigned DsrW = 17
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic [DvdW-1:0] dividend_i,
    input  logic [DsrW-1:0] divisor_i,
    output logic            done_o,
    output logic [DvdW-1:0] quotient_o
);

    localparam int unsigned CntW = $clog2(DvdW + 1);

    // quo_q starts as the dividend; dividend bits shift out the top while quotient bits shift in.
    logic [DsrW-1:0] rem_q, rem_d;
    logic [DvdW-1:0] quo_q, quo_d;
    logic [DsrW-1:0] dsr_q, dsr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            busy_q, busy_d;

    logic [DsrW:0]   trial;
    logic [DsrW:0]   trial_sub;
    logic            ge;

    // Next-state: load on start, otherwise one trial subtraction per busy cycle.
    always_comb begin
        trial     = {rem_q, quo_q[DvdW-1]};
        ge        = (trial >= {1'b0, dsr_q});
        trial_sub = trial - {1'b0, dsr_q};
        rem_d     = rem_q;
        quo_d     = quo_q;
        dsr_d     = dsr_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        if (start_i) begin
            rem_d  = '0;
            quo_d  = dividend_i;
            dsr_d  = divisor_i;
            cnt_d  = CntW'(DvdW);
            busy_d = 1'b1;
        end else if (busy_q) begin
            // Partial remainder stays below the divisor, so DsrW bits always suffice.
            rem_d  = ge ? trial_sub[DsrW-1:0] : trial[DsrW-1:0];
            quo_d  = {quo_q[DvdW-2:0], ge};
            cnt_d  = cnt_q - CntW'(1);
            busy_d = (cnt_q != CntW'(1));
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dsr_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dsr_q  <= dsr_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign done_o     = busy_q && (cnt_q == CntW'(1));
    assign quotient_o = quo_q;

endmodule

// File: rtl/sfp_vec_div_s.sv
// Sequential signed fixed-point vector / scalar divide: out[i] = a[i] / s, components in order.
// Optional macro SFP_VEC_DIV_ROUND_EN: one guard quotient bit and half-away-from-zero rounding
// (latency N*(Q+3)); without it the quotient truncates toward zero (latency N*(Q+2)).
module sfp_vec_div_s
    import sfp_vec_div_s_pkg::*;
#(
    parameter int unsigned N    = 3,
    parameter int unsigned IW   = 8,
    parameter int unsigned FW   = 8,
    parameter int unsigned CLIP = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [N*(IW+FW)-1:0]  a_i,
    input  logic [IW+FW-1:0]      s_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [N*(IW+FW)-1:0]  out_o,
    output logic                  div_by_zero_o,
    output logic                  clipping_o
);

    localparam int unsigned W = IW + FW;
`ifdef SFP_VEC_DIV_ROUND_EN
    localparam int unsigned Guard = 1;
`else
    localparam int unsigned Guard = 0;
`endif
    localparam int unsigned DvdW = W + FW + Guard;
    localparam int unsigned MagW = W + 1;
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

    localparam logic signed [SfpCalcW-1:0] MaxV = sfp_max(W);
    localparam logic signed [SfpCalcW-1:0] MinV = sfp_min(W);
    localparam logic [W-1:0]               MaxW = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]               MinW = {1'b1, {(W-1){1'b0}}};

    div_state_e           state_q, state_d;
    logic [N*W-1:0]       a_q, a_d;
    logic [W-1:0]         s_q, s_d;
    logic [IdxW-1:0]      idx_q, idx_d;
    logic                 sign_q, sign_d;
    logic                 dbz_q, dbz_d;
    logic                 clip_q, clip_d;
    logic [N*W-1:0]       out_q, out_d;

    logic [W-1:0]         a_cur;
    logic [MagW-1:0]      mag_a;
    logic [MagW-1:0]      mag_s;
    logic [DvdW-1:0]      dividend;
    logic                 div_start;
    logic                 div_done;
    logic [DvdW-1:0]      div_quo;
    logic [DvdW-1:0]      qmag;
    logic signed [SfpCalcW-1:0] mag_w;
    logic signed [SfpCalcW-1:0] val;
    logic signed [SfpCalcW-1:0] sat;
    logic                 ovf;
    logic [W-1:0]         res;
    logic                 res_clip;
    logic [SfpCalcW-W-1:0] unused_sat_hi;

    // Select the component under work and form operand magnitudes (W+1 bits so -2^(W-1) fits).
    always_comb begin
        a_cur = '0;
        for (int i = 0; i < N; i++) begin
            if (idx_q == IdxW'(i)) begin
                a_cur = a_q[i*W +: W];
            end
        end
        mag_a    = a_cur[W-1] ? (MagW'(0) - {a_cur[W-1], a_cur}) : {1'b0, a_cur};
        mag_s    = s_q[W-1] ? (MagW'(0) - {s_q[W-1], s_q}) : {1'b0, s_q};
        dividend = DvdW'(mag_a) << (FW + Guard);
    end

    sfp_vec_div_s_div_seq #(
        .DvdW (DvdW),
        .DsrW (MagW)
    ) u_div_seq (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .start_i    (div_start),
        .dividend_i (dividend),
        .divisor_i  (mag_s),
        .done_o     (div_done),
        .quotient_o (div_quo)
    );

    // Apply rounding, sign and overflow handling to the finished quotient magnitude.
    always_comb begin
`ifdef SFP_VEC_DIV_ROUND_EN
        // The guard bit set means the discarded fraction is at least one half: round up.
        qmag = (div_quo >> 1) + DvdW'(div_quo[0]);
`else
        qmag = div_quo;
`endif
        mag_w         = $signed(SfpCalcW'(qmag));
        val           = sign_q ? -mag_w : mag_w;
        ovf           = (val > MaxV) || (val < MinV);
        sat           = sfp_sat(val, W);
        unused_sat_hi = sat[SfpCalcW-1:W];
        res           = (CLIP != 0) ? sat[W-1:0] : val[W-1:0];
        res_clip      = ovf;
        if (dbz_q) begin
            // Division by zero: saturate toward the dividend's sign, or zero when wrapping.
            res_clip = (a_cur != '0);
            if (CLIP != 0 && a_cur != '0) begin
                res = a_cur[W-1] ? MinW : MaxW;
            end else begin
                res = '0;
            end
        end
    end

    // FSM next-state, datapath updates and handshake outputs.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        s_d         = s_q;
        idx_d       = idx_q;
        sign_d      = sign_q;
        dbz_d       = dbz_q;
        clip_d      = clip_q;
        out_d       = out_q;
        div_start   = 1'b0;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    a_d     = a_i;
                    s_d     = s_i;
                    idx_d   = '0;
                    dbz_d   = (s_i == '0);
                    clip_d  = 1'b0;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                div_start = 1'b1;
                sign_d    = a_cur[W-1] ^ s_q[W-1];
                state_d   = StDiv;
            end
            StDiv: begin
                if (div_done) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                for (int i = 0; i < N; i++) begin
                    if (idx_q == IdxW'(i)) begin
                        out_d[i*W +: W] = res;
                    end
                end
                clip_d = clip_q | res_clip;
                if (idx_q == IdxW'(N - 1)) begin
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + IdxW'(1);
                    state_d = StSetup;
                end
            end
            StDone: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers; reset discards any vector in flight.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            a_q     <= '0;
            s_q     <= '0;
            idx_q   <= '0;
            sign_q  <= 1'b0;
            dbz_q   <= 1'b0;
            clip_q  <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            s_q     <= s_d;
            idx_q   <= idx_d;
            sign_q  <= sign_d;
            dbz_q   <= dbz_d;
            clip_q  <= clip_d;
            out_q   <= out_d;
        end
    end

    assign out_o         = out_q;
    assign div_by_zero_o = dbz_q;
    assign clipping_o    = clip_q;

endmodule

// File: tb/tb_sfp_vec_div_s.sv
// Scoreboard bench for sfp_vec_div_s: stimulus pushes model results, a monitor pops and compares.
module tb_sfp_vec_div_s;

    localparam int N    = 3;
    localparam int IW   = 8;
    localparam int FW   = 8;
    localparam int CLIP = 1;
    localparam int W    = IW + FW;
    localparam int Q    = W + FW;
`ifdef SFP_VEC_DIV_ROUND_EN
    localparam int G = 1;
`else
    localparam int G = 0;
`endif
    localparam int LAT = N * (Q + 2 + G);
    localparam longint MAXV = (64'sd1 <<< (W - 1)) - 64'sd1;
    localparam longint MINV = -(64'sd1 <<< (W - 1));

    typedef struct {
        logic [N*W-1:0] out;
        logic           dbz;
        logic           clip;
        longint         acc;
    } exp_t;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [N*W-1:0] a_i;
    logic [W-1:0]   s_i;
    logic           out_valid;
    logic           out_ready;
    logic [N*W-1:0] out_o;
    logic           dbz;
    logic           clip;

    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    int     rdy_mode = 0;
    exp_t   sb[$];

    sfp_vec_div_s #(
        .N    (N),
        .IW   (IW),
        .FW   (FW),
        .CLIP (CLIP)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready),
        .a_i           (a_i),
        .s_i           (s_i),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .out_o         (out_o),
        .div_by_zero_o (dbz),
        .clipping_o    (clip)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: exact rational a*2^FW/s with integer division, then range handling.
    function automatic exp_t model(input logic [N*W-1:0] a, input logic [W-1:0] s);
        exp_t        e;
        longint      den, num, q, an, dn;
        logic [63:0] bits;
        e.out  = '0;
        e.dbz  = (s == '0);
        e.clip = 1'b0;
        e.acc  = 0;
        den    = longint'($signed(s));
        for (int i = 0; i < N; i++) begin
            num = longint'($signed(a[i*W +: W])) * (64'sd1 <<< FW);
            if (den == 0) begin
                if (CLIP != 0) q = (num > 0) ? MAXV : ((num < 0) ? MINV : 0);
                else q = 0;
                if (num != 0) e.clip = 1'b1;
            end else begin
                an = (num < 0) ? -num : num;
                dn = (den < 0) ? -den : den;
                if (G != 0) q = (2 * an + dn) / (2 * dn);
                else q = an / dn;
                if ((num < 0) != (den < 0)) q = -q;
                if (q > MAXV || q < MINV) begin
                    e.clip = 1'b1;
                    if (CLIP != 0) q = (q > MAXV) ? MAXV : MINV;
                end
            end
            bits = q;
            e.out[i*W +: W] = bits[W-1:0];
        end
        return e;
    endfunction

    task automatic send(input logic [N*W-1:0] a, input logic [W-1:0] s);
        exp_t e;
        int   n;
        n = 0;
        while (!in_ready && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            check("in_ready_wait_timeout", 64'd0, 64'd1);
            return;
        end
        a_i      = a;
        s_i      = s;
        in_valid = 1'b1;
        e        = model(a, s);
        @(posedge clk);
        #1;
        e.acc    = cyc;
        sb.push_back(e);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    // Consumer ready pattern, applied shortly after each rising edge.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: latency on valid rise, hold stability, result compare on handshake.
    initial begin
        bit             pv;
        bit             phs;
        logic [N*W-1:0] held_o;
        logic           held_d, held_c;
        exp_t           e;
        pv  = 1'b0;
        phs = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pv  = 1'b0;
                phs = 1'b0;
                continue;
            end
            if (phs) begin
                check("in_ready_after_handshake", 64'(in_ready), 64'd1);
                phs = 1'b0;
            end
            if (out_valid) begin
                check("in_ready_low_while_valid", 64'(in_ready), 64'd0);
                if (!pv) begin
                    held_o = out_o;
                    held_d = dbz;
                    held_c = clip;
                    if (sb.size() == 0) check("unexpected_output", 64'd1, 64'd0);
                    else check("latency", 64'(cyc - sb[0].acc), 64'(LAT));
                end else begin
                    check("hold_out", 64'(out_o), 64'(held_o));
                    check("hold_flags", 64'({dbz, clip}), 64'({held_d, held_c}));
                end
                if (out_ready && sb.size() != 0) begin
                    e = sb.pop_front();
                    check("out_vec", 64'(out_o), 64'(e.out));
                    check("div_by_zero", 64'(dbz), 64'(e.dbz));
                    check("clipping", 64'(clip), 64'(e.clip));
                end
                if (out_ready) phs = 1'b1;
            end
            pv = out_valid && !out_ready;
        end
    end

    initial begin
        int             n;
        logic [N*W-1:0] ra;
        logic [W-1:0]   rs;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a_i      = '0;
        s_i      = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out", 64'(out_o), 64'd0);
        check("reset_dbz", 64'(dbz), 64'd0);
        check("reset_clip", 64'(clip), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors.
        send({16'h0080, 16'hFD00, 16'h0200}, 16'h0200);
        send({16'h0000, 16'h0000, 16'h6400}, 16'h0040);
        send({16'h0000, 16'hFF00, 16'h0100}, 16'h0000);
        send({16'h0000, 16'h0000, 16'h0001}, 16'h0200);
        send({16'h0000, 16'h0000, 16'h0100}, 16'h0300);
        send({16'h7FFF, 16'h8000, 16'h8000}, 16'hFFFF);
        send({16'h7FFF, 16'h0100, 16'h8000}, 16'h8000);
        send({16'h0000, 16'h0000, 16'h0000}, 16'h0000);
        drain();

        // Backpressure with ignored input traffic while the result is held.
        rdy_mode = 2;
        send({16'h0300, 16'hF000, 16'h1234}, 16'hFE00);
        n = 0;
        while (!out_valid && n < LAT + 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("bp_valid_seen", 64'(out_valid), 64'd1);
        in_valid = 1'b1;
        a_i      = {16'h1111, 16'h2222, 16'h3333};
        s_i      = 16'h0100;
        repeat (20) @(posedge clk);
        #1;
        in_valid = 1'b0;
        rdy_mode = 0;
        drain();

        // Reset in the middle of a vector.
        send({16'h0400, 16'h0500, 16'h0600}, 16'h0100);
        repeat (29) @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("midreset_in_ready", 64'(in_ready), 64'd1);
        check("midreset_out_valid", 64'(out_valid), 64'd0);
        send({16'hFF80, 16'h0A00, 16'h0180}, 16'h0300);
        drain();

        // Randomized vectors with random consumer stalls.
        rdy_mode = 1;
        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 1) == 0) ra[i*W +: W] = 16'($urandom);
                else ra[i*W +: W] = 16'($signed(16'($urandom_range(0, 16'h0FFF))) - 16'sh0800);
            end
            case ($urandom_range(0, 4))
                0: rs = 16'h0000;
                1: rs = 16'h8000;
                2: rs = 16'($urandom);
                3: rs = 16'($urandom_range(16'h0100, 16'h7FFF));
                default: rs = 16'($urandom_range(1, 255));
            endcase
            if ($urandom_range(0, 1) == 1) rs = 16'h0000 - rs;
            send(ra, rs);
        end
        drain();
        rdy_mode = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
